// File: rtl/pc_fetch_unit.sv
// Program counter stage: next-PC selection, trap vectoring,
// link/return address generation and retired-instruction count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        irq_i,
  input  logic        exc_undef_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o,
  output logic        kernel_mode_o,
  output logic [31:0] retired_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ret_q, ret_d;
  logic        irq_meta_q, irq_s_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_off, br_tgt;
  logic        irq_take;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    br_tgt   = pc_plus4 + br_off;
    irq_take = irq_s_q && !pc_q[31];
  end

  // Only the JR path may drop the supervisor bit.
  always_comb begin
    pc_d     = pc_q;
    ret_d    = ret_q + 32'd1;
    epc_o    = pc_q;
    epc_we_o = 1'b0;
    priority case (1'b1)
      stall_i: begin
        ret_d = ret_q;
      end
      exc_undef_i: begin
        pc_d     = EXC_VECTOR;
        ret_d    = ret_q;
        epc_o    = pc_plus4;
        epc_we_o = 1'b1;
      end
      irq_take: begin
        pc_d     = IRQ_VECTOR;
        ret_d    = ret_q;
        epc_o    = pc_q;
        epc_we_o = 1'b1;
      end
      jr_i: begin
        pc_d = {jr_target_i[31:2], 2'b00};
      end
      jump_i: begin
        pc_d = {pc_q[31], pc_plus4[30:28],
                jump_target_i, 2'b00};
      end
      branch_taken_i: begin
        pc_d = {pc_q[31], br_tgt[30:0]};
      end
      default: begin
        pc_d = {pc_q[31], pc_plus4[30:0]};
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= RESET_VECTOR;
      ret_q      <= 32'd0;
      irq_meta_q <= 1'b0;
      irq_s_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ret_q      <= ret_d;
      irq_meta_q <= irq_i;
      irq_s_q    <= irq_meta_q;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign kernel_mode_o = pc_q[31];
  assign retired_o     = ret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios,
// then randomized traffic against a reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] EV = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        stall_i, branch_taken_i, jump_i, jr_i;
  logic        irq_i, exc_undef_i;
  logic [15:0] branch_imm_i;
  logic [25:0] jump_target_i;
  logic [31:0] jr_target_i;
  logic [31:0] pc_o, pc_plus4_o, epc_o, retired_o;
  logic        epc_we_o, kernel_mode_o;

  pc_fetch_unit dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .stall_i       (stall_i),
    .branch_taken_i(branch_taken_i),
    .branch_imm_i  (branch_imm_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .jr_i          (jr_i),
    .jr_target_i   (jr_target_i),
    .irq_i         (irq_i),
    .exc_undef_i   (exc_undef_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .epc_o         (epc_o),
    .epc_we_o      (epc_we_o),
    .kernel_mode_o (kernel_mode_o),
    .retired_o     (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] epc;
    logic        we;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference state
  logic [31:0] m_pc, m_ret;
  bit          m_s1, m_s2;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] keep31(input logic [31:0] v,
                                         input logic [31:0] ref_pc);
    return (v & 32'h7FFF_FFFF) | (ref_pc & 32'h8000_0000);
  endfunction

  function automatic bit trap_exc();
    return !stall_i && exc_undef_i;
  endfunction

  function automatic bit trap_irq();
    return !stall_i && !exc_undef_i && m_s2 && !m_pc[31];
  endfunction

  task automatic push_exp();
    exp_t e;
    e.pc  = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.we  = reset_ni && (trap_exc() || trap_irq());
    e.epc = trap_exc() ? m_pc + 32'd4 : m_pc;
    e.ret = m_ret;
    q.push_back(e);
  endtask

  task automatic model_edge();
    logic [31:0] seq;
    int signed   off;
    if (!reset_ni) return;
    seq = m_pc + 32'd4;
    off = int'($signed(branch_imm_i)) * 4;
    if (stall_i) begin
    end else if (exc_undef_i) m_pc = EV;
    else if (m_s2 && !m_pc[31]) m_pc = IV;
    else begin
      if (jr_i) m_pc = jr_target_i & 32'hFFFF_FFFC;
      else if (jump_i)
        m_pc = keep31((seq & 32'hF000_0000) |
                      (32'(jump_target_i) << 2), m_pc);
      else if (branch_taken_i)
        m_pc = keep31(seq + 32'(off), m_pc);
      else m_pc = keep31(seq, m_pc);
      m_ret = m_ret + 32'd1;
    end
    m_s2 = m_s1;
    m_s1 = irq_i;
  endtask

  task automatic clear_in();
    stall_i = 0; branch_taken_i = 0; branch_imm_i = '0;
    jump_i = 0; jump_target_i = '0; jr_i = 0; jr_target_i = '0;
    exc_undef_i = 0;
  endtask

  // Called right after a falling edge; returns after the next one.
  task automatic cyc();
    #1 push_exp();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_in();
      cyc();
    end
  endtask

  task automatic go_jr(input logic [31:0] t);
    clear_in(); jr_i = 1; jr_target_i = t;
    cyc();
  endtask

  task automatic do_reset();
    clear_in();
    irq_i    = 0;
    reset_ni = 0;
    m_pc = RV; m_ret = 0; m_s1 = 0; m_s2 = 0;
    cyc();
    reset_ni = 1;
  endtask

  always begin
    @(negedge clk);
    #2;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("pc_plus4", pc_plus4_o, e.pc4);
      chk("kernel_mode", 32'(kernel_mode_o), 32'(e.pc[31]));
      chk("retired", retired_o, e.ret);
      chk("epc_we", 32'(epc_we_o), 32'(e.we));
      if (e.we) chk("epc", epc_o, e.epc);
    end
  end

  initial begin
    reset_ni = 0;
    irq_i    = 0;
    clear_in();
    m_pc = RV; m_ret = 0; m_s1 = 0; m_s2 = 0;
    @(negedge clk);
    do_reset();
    idle(4);

    go_jr(32'h8000_0010);
    clear_in(); branch_taken_i = 1; branch_imm_i = 16'hFFFE; cyc();
    go_jr(32'h8000_0000);
    clear_in(); branch_taken_i = 1; branch_imm_i = 16'h7FFF; cyc();
    idle(1);

    go_jr(32'h8000_0020);
    go_jr(32'h0040_0003);
    clear_in(); jump_i = 1; jump_target_i = 26'h0000010; cyc();
    idle(1);

    go_jr(32'h0040_0008);
    irq_i = 1;
    idle(4);
    clear_in(); jr_i = 1; jr_target_i = 32'h8000_0100; cyc();
    idle(3);
    irq_i = 0;
    idle(3);

    go_jr(32'h0040_0010);
    clear_in(); exc_undef_i = 1; jr_i = 1;
    jr_target_i = 32'h0000_1000; cyc();
    go_jr(32'h0040_0010);
    clear_in(); stall_i = 1; exc_undef_i = 1; jr_i = 1;
    jr_target_i = 32'h0000_1000; cyc();
    idle(1);

    go_jr(32'h0040_0100);
    #3 reset_ni = 0;
    #1 chk("async_reset_pc", pc_o, RV);
    chk("async_reset_ret", retired_o, 32'd0);
    @(negedge clk);
    do_reset();
    idle(2);

    for (int i = 0; i < 400; i++) begin
      int r;
      clear_in();
      if ($urandom_range(0, 9) == 0) irq_i = ~irq_i;
      stall_i        = ($urandom_range(0, 4) == 0);
      exc_undef_i    = ($urandom_range(0, 19) == 0);
      r              = $urandom_range(0, 9);
      jr_i           = (r == 0);
      jump_i         = (r <= 2);
      branch_taken_i = (r <= 5);
      jr_target_i    = $urandom;
      jump_target_i  = 26'($urandom);
      branch_imm_i   = 16'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc();
    end

    idle(2);
    #5;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
